// File: rtl/count_display_if.sv
// Bundle between the mod-N counter side and the display driver: counter
// state and tally control in, wrap strobe, tally and display drive out.
interface count_display_if;
  logic [3:0] count;
  logic       direction;
  logic [3:0] N;
  logic       clear_wraps;
  logic       wrap_pulse;
  logic [7:0] wraps;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output count, direction, N, clear_wraps,
    input  wrap_pulse, wraps, seg, dp, an
  );

  modport slave (
    input  count, direction, N, clear_wraps,
    output wrap_pulse, wraps, seg, dp, an
  );
endinterface

// File: rtl/count_display_driver.sv
// Display driver for the mod-N up/down counter: samples the counter, counts
// wraps in a 2-digit BCD tally and scans a 4-digit 7-segment display
// (digits 1:0 = count in decimal, 3:2 = wrap tally, dp = counting down).
module count_display_driver #(
  parameter int REFRESH_DIV    = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic            clk,
  input logic            reset,
  count_display_if.slave bus
);

  localparam int              DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [6:0]       SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic             DP_IDLE  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [3:0]       AN_IDLE  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit, input logic blank);
    logic [6:0] pat;
    if (blank) begin
      pat = 7'h00;
    end else begin
      case (digit)
        4'd0:    pat = 7'h3F;
        4'd1:    pat = 7'h06;
        4'd2:    pat = 7'h5B;
        4'd3:    pat = 7'h4F;
        4'd4:    pat = 7'h66;
        4'd5:    pat = 7'h6D;
        4'd6:    pat = 7'h7D;
        4'd7:    pat = 7'h07;
        4'd8:    pat = 7'h7F;
        4'd9:    pat = 7'h6F;
        default: pat = 7'h00;
      endcase
    end
    return pat;
  endfunction

  logic [3:0]       c1_r, c2_r, m1_r;
  logic             d1_r;
  logic             det_s, det_r, wrap_pulse_r;
  logic [3:0]       ones_r, tens_r;
  logic [DIV_W-1:0] div_r;
  logic [1:0]       idx_r;
  logic [3:0]       digit_s;
  logic             blank_s;
  logic [3:0]       an_hot_s;
  logic             dp_s;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic [3:0]       an_r;

  // Input stage: sample counter state, last-count value (N-1), and a delayed copy of count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c1_r <= 4'd0;
      c2_r <= 4'd0;
      m1_r <= 4'd0;
      d1_r <= 1'b0;
    end else begin
      c1_r <= bus.count;
      c2_r <= c1_r;
      m1_r <= bus.N - 4'd1;
      d1_r <= bus.direction;
    end
  end

  // Wrap detect: only the exact last->0 (up) or 0->last (down) step counts.
  always_comb begin
    det_s = 1'b0;
    if (c1_r != c2_r) begin
      if (!d1_r) begin
        det_s = (c2_r == m1_r) && (c1_r == 4'd0);
      end else begin
        det_s = (c2_r == 4'd0) && (c1_r == m1_r);
      end
    end else begin
      det_s = 1'b0;
    end
  end

  // Wrap strobe pipeline and BCD tally; clear beats a coincident increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_r        <= 1'b0;
      wrap_pulse_r <= 1'b0;
      ones_r       <= 4'd0;
      tens_r       <= 4'd0;
    end else begin
      det_r        <= det_s;
      wrap_pulse_r <= det_r;
      if (bus.clear_wraps) begin
        ones_r <= 4'd0;
        tens_r <= 4'd0;
      end else if (det_r) begin
        if (ones_r == 4'd9) begin
          ones_r <= 4'd0;
          tens_r <= (tens_r == 4'd9) ? 4'd0 : tens_r + 4'd1;
        end else begin
          ones_r <= ones_r + 4'd1;
        end
      end
    end
  end

  // Refresh divider and digit scan index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r <= '0;
      idx_r <= 2'd0;
    end else if (div_r == DIV_LAST) begin
      div_r <= '0;
      idx_r <= idx_r + 2'd1;
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // Select digit value, blanking and enable for the current scan index.
  always_comb begin
    digit_s  = 4'd0;
    blank_s  = 1'b1;
    an_hot_s = 4'b0000;
    case (idx_r)
      2'd0: begin
        digit_s  = (c1_r >= 4'd10) ? c1_r - 4'd10 : c1_r;
        blank_s  = 1'b0;
        an_hot_s = 4'b0001;
      end
      2'd1: begin
        digit_s  = (c1_r >= 4'd10) ? 4'd1 : 4'd0;
        blank_s  = (c1_r < 4'd10);
        an_hot_s = 4'b0010;
      end
      2'd2: begin
        digit_s  = ones_r;
        blank_s  = 1'b0;
        an_hot_s = 4'b0100;
      end
      2'd3: begin
        digit_s  = tens_r;
        blank_s  = 1'b0;
        an_hot_s = 4'b1000;
      end
      default: begin
        digit_s  = 4'd0;
        blank_s  = 1'b1;
        an_hot_s = 4'b0000;
      end
    endcase
    dp_s = (idx_r == 2'd0) && d1_r;
  end

  // Registered display drive with board polarity applied after decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_r <= SEG_IDLE;
      dp_r  <= DP_IDLE;
      an_r  <= AN_IDLE;
    end else begin
      seg_r <= SEG_ACTIVE_LOW ? ~seg_decode(digit_s, blank_s) : seg_decode(digit_s, blank_s);
      dp_r  <= SEG_ACTIVE_LOW ? ~dp_s : dp_s;
      an_r  <= AN_ACTIVE_LOW ? ~an_hot_s : an_hot_s;
    end
  end

  assign bus.wrap_pulse = wrap_pulse_r;
  assign bus.wraps      = {tens_r, ones_r};
  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.an         = an_r;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver: reset state, scan order, wrap
// detection in both directions, tally rollover/clear and display polarity.
module tb_count_display_driver;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  count_display_if bus ();
  count_display_if bus2 ();

  assign bus2.count       = bus.count;
  assign bus2.direction   = bus.direction;
  assign bus2.N           = bus.N;
  assign bus2.clear_wraps = bus.clear_wraps;

  count_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
    dut (.clk(clk), .reset(reset), .bus(bus.slave));

  count_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1))
    dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance n cycles, counting pulses and pulses wider than one cycle.
  task automatic run_cycles(input int n, inout int pulses, inout int wide);
    logic prev;
    prev = bus.wrap_pulse;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (bus.wrap_pulse && prev) wide++;
      if (bus.wrap_pulse) pulses++;
      prev = bus.wrap_pulse;
    end
  endtask

  // Wait (bounded) for the second instance to enable a given digit.
  task automatic wait_an2(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus2.an == target) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.count = 4'd0;
    bus.direction = 1'b0;
    bus.N = 4'd10;
    bus.clear_wraps = 1'b0;
    tick(3);
    tests++;
    if (bus.wrap_pulse !== 1'b0 || bus.wraps !== 8'h00) begin
      fails++;
      $display("FAIL reset_tally: pulse=%b wraps=%h expected 0 / 00", bus.wrap_pulse, bus.wraps);
    end
    tests++;
    if (bus.seg !== 7'h7F || bus.dp !== 1'b1 || bus.an !== 4'hF) begin
      fails++;
      $display("FAIL reset_display: seg=%h dp=%b an=%b expected 7f 1 1111", bus.seg, bus.dp, bus.an);
    end
    reset = 1'b0;
    tick(1);
    tests++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'h40 || bus.dp !== 1'b1) begin
      fails++;
      $display("FAIL first_digit: an=%b seg=%h dp=%b expected 1110 40 1", bus.an, bus.seg, bus.dp);
    end
    tick(4);
    tests++;
    if (bus.an !== 4'b1101 || bus.seg !== 7'h7F) begin
      fails++;
      $display("FAIL second_digit: an=%b seg=%h expected 1101 7f", bus.an, bus.seg);
    end
  endtask

  task automatic test_up_wrap;
    logic [3:0] exp_p[4];
    exp_p[0] = 4'd0; exp_p[1] = 4'd0; exp_p[2] = 4'd1; exp_p[3] = 4'd0;
    bus.N = 4'd10;
    bus.direction = 1'b0;
    for (int v = 0; v < 10; v++) begin
      bus.count = 4'(v);
      tick(1);
    end
    bus.count = 4'd0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      tests++;
      if (bus.wrap_pulse !== exp_p[k][0]) begin
        fails++;
        $display("FAIL up_wrap_timing: edge %0d pulse=%b expected %b", k + 1, bus.wrap_pulse, exp_p[k][0]);
      end
    end
    tests++;
    if (bus.wraps !== 8'h01) begin
      fails++;
      $display("FAIL up_wrap_tally: wraps=%h expected 01", bus.wraps);
    end
  endtask

  task automatic test_down_wrap;
    int p;
    int w;
    p = 0; w = 0;
    bus.direction = 1'b1;
    bus.count = 4'd1; run_cycles(1, p, w);
    bus.count = 4'd0; run_cycles(1, p, w);
    bus.count = 4'd9; run_cycles(5, p, w);
    tests++;
    if (p !== 1 || bus.wraps !== 8'h02) begin
      fails++;
      $display("FAIL down_wrap: pulses=%0d wraps=%h expected 1 / 02", p, bus.wraps);
    end
    p = 0;
    bus.count = 4'd8; run_cycles(1, p, w);
    bus.count = 4'd0; run_cycles(5, p, w);
    tests++;
    if (p !== 0 || bus.wraps !== 8'h02) begin
      fails++;
      $display("FAIL down_jump_no_wrap: pulses=%0d wraps=%h expected 0 / 02", p, bus.wraps);
    end
  endtask

  task automatic test_rollover;
    int p;
    int w;
    p = 0; w = 0;
    bus.direction = 1'b0;
    bus.count = 4'd0;
    bus.clear_wraps = 1'b1;
    tick(1);
    bus.clear_wraps = 1'b0;
    tick(3);
    tests++;
    if (bus.wraps !== 8'h00) begin
      fails++;
      $display("FAIL clear_wraps: wraps=%h expected 00", bus.wraps);
    end
    bus.N = 4'd2;
    for (int i = 0; i < 99; i++) begin
      bus.count = 4'd1; run_cycles(1, p, w);
      bus.count = 4'd0; run_cycles(1, p, w);
    end
    run_cycles(4, p, w);
    tests++;
    if (p !== 99 || bus.wraps !== 8'h99) begin
      fails++;
      $display("FAIL tally_99: pulses=%0d wraps=%h expected 99 / 99", p, bus.wraps);
    end
    bus.count = 4'd1; run_cycles(1, p, w);
    bus.count = 4'd0; run_cycles(4, p, w);
    tests++;
    if (p !== 100 || bus.wraps !== 8'h00) begin
      fails++;
      $display("FAIL tally_rollover: pulses=%0d wraps=%h expected 100 / 00", p, bus.wraps);
    end
    tests++;
    if (w !== 0) begin
      fails++;
      $display("FAIL pulse_width: wide pulses=%0d expected 0", w);
    end
  endtask

  task automatic test_n_edge;
    int p;
    int w;
    p = 0; w = 0;
    bus.N = 4'd1;
    bus.count = 4'd0;
    bus.direction = 1'b0;
    run_cycles(6, p, w);
    bus.direction = 1'b1;
    run_cycles(6, p, w);
    tests++;
    if (p !== 0) begin
      fails++;
      $display("FAIL n1_no_wrap: pulses=%0d expected 0", p);
    end
    bus.N = 4'd0;
    bus.direction = 1'b0;
    bus.count = 4'd15; run_cycles(3, p, w);
    bus.count = 4'd0;  run_cycles(5, p, w);
    tests++;
    if (p !== 1 || bus.wraps !== 8'h01) begin
      fails++;
      $display("FAIL n0_wrap: pulses=%0d wraps=%h expected 1 / 01", p, bus.wraps);
    end
  endtask

  task automatic test_clear_priority;
    int p;
    int w;
    p = 0; w = 0;
    bus.N = 4'd2;
    bus.direction = 1'b0;
    bus.count = 4'd0;
    bus.clear_wraps = 1'b1;
    tick(1);
    bus.clear_wraps = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.count = 4'd1; run_cycles(1, p, w);
      bus.count = 4'd0; run_cycles(1, p, w);
    end
    run_cycles(4, p, w);
    tests++;
    if (bus.wraps !== 8'h05) begin
      fails++;
      $display("FAIL preload_05: wraps=%h expected 05", bus.wraps);
    end
    bus.count = 4'd1; tick(1);
    bus.count = 4'd0; tick(1);
    tick(1);
    bus.clear_wraps = 1'b1;
    tick(1);
    bus.clear_wraps = 1'b0;
    tests++;
    if (bus.wrap_pulse !== 1'b1 || bus.wraps !== 8'h00) begin
      fails++;
      $display("FAIL clear_priority: pulse=%b wraps=%h expected 1 / 00", bus.wrap_pulse, bus.wraps);
    end
    tick(1);
    tests++;
    if (bus.wrap_pulse !== 1'b0 || bus.wraps !== 8'h00) begin
      fails++;
      $display("FAIL after_clear: pulse=%b wraps=%h expected 0 / 00", bus.wrap_pulse, bus.wraps);
    end
  endtask

  task automatic test_reset_mid_scan;
    bit ok;
    wait_an2(4'b1011, ok);
    tests++;
    if (!ok || bus.an !== 4'b1011) begin
      fails++;
      $display("FAIL reach_index2: an=%b expected 1011", bus.an);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1 || bus.wraps !== 8'h00) begin
      fails++;
      $display("FAIL async_reset: an=%b seg=%h dp=%b wraps=%h expected 1111 7f 1 00",
               bus.an, bus.seg, bus.dp, bus.wraps);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1);
    tests++;
    if (bus.an !== 4'b1110) begin
      fails++;
      $display("FAIL restart_an0: an=%b expected 1110", bus.an);
    end
  endtask

  task automatic test_dp_polarity;
    bit ok;
    bus.N = 4'd0;
    bus.direction = 1'b1;
    bus.count = 4'd13;
    tick(20);
    wait_an2(4'b1110, ok);
    tests++;
    if (!ok || bus2.seg !== 7'h4F || bus2.dp !== 1'b1) begin
      fails++;
      $display("FAIL hi_idx0: seg=%h dp=%b expected 4f 1", bus2.seg, bus2.dp);
    end
    tests++;
    if (bus.seg !== 7'h30 || bus.dp !== 1'b0) begin
      fails++;
      $display("FAIL lo_idx0: seg=%h dp=%b expected 30 0", bus.seg, bus.dp);
    end
    wait_an2(4'b1101, ok);
    tests++;
    if (!ok || bus2.seg !== 7'h06 || bus2.dp !== 1'b0) begin
      fails++;
      $display("FAIL hi_idx1: seg=%h dp=%b expected 06 0", bus2.seg, bus2.dp);
    end
    wait_an2(4'b1011, ok);
    tests++;
    if (!ok || bus2.seg !== 7'h3F) begin
      fails++;
      $display("FAIL hi_idx2: seg=%h expected 3f", bus2.seg);
    end
    wait_an2(4'b0111, ok);
    tests++;
    if (!ok || bus2.seg !== 7'h3F || bus2.dp !== 1'b0) begin
      fails++;
      $display("FAIL hi_idx3_unblanked: seg=%h dp=%b expected 3f 0", bus2.seg, bus2.dp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_rollover();
    test_n_edge();
    test_clear_priority();
    test_reset_mid_scan();
    test_dp_polarity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
- Downstream consumer of the mod-N up/down counter.
- Samples the counter's count, direction and N; detects wrap events; keeps a 2-digit BCD wrap tally.
- Drives a 4-digit time-multiplexed 7-segment display:
  - Digits 1:0 show the count in decimal.
  - Digits 3:2 show the wrap tally.
  - The decimal point flags down-counting.

Parameters:
- REFRESH_DIV, 4, clk cycles each digit stays enabled (≥2; 50000 on board, 4 in sim).
- SEG_ACTIVE_LOW, 1, 1 = seg/dp outputs inverted (common-anode).
- AN_ACTIVE_LOW, 1, 1 = an outputs inverted.

Ports:
- clk  input  1  system clock, same domain as the counter
- reset  input  1  asynchronous, active-high reset
- count  input  4  counter value
- direction  input  1  counter direction, 0 = up, 1 = down
- N  input  4  counter modulus
- clear_wraps  input  1  synchronous clear of the wrap tally
- wrap_pulse  output  1  one-cycle strobe per detected wrap
- wraps  output  8  wrap tally, BCD {tens, ones}, 00–99
- seg  output  7  segments {g,f,e,d,c,b,a}
- dp  output  1  decimal point
- an  output  4  digit enables, an[0] = rightmost digit

Behaviour:
- Reset (async, any time, including mid-scan or mid-wrap):
  - All registers clear.
  - wrap_pulse=0, wraps=8'h00.
  - Scan index=0, divider=0.
  - seg, dp and an are all at inactive level: seg=7'h7F, dp=1, an=4'hF with default polarity.
- Input stage:
  - Every edge registers count→c1, direction→d1, (N-1) mod 16→m1.
  - Every edge also registers c1→c2.
- Wrap detect (compare c1 against c2):
  - Up wrap: d1=0, c2=m1, c1=0, c1≠c2.
  - Down wrap: d1=1, c2=0, c1=m1, c1≠c2.
  - N=1 (m1=0) never produces a wrap.
  - N=0 gives m1=15, so 15↔0 wraps count.
  - Any other jump (e.g. N changed mid-run, or a direction flip) is not a wrap.
- wrap_pulse is registered: high exactly one cycle, 3 clk edges after the edge at which count first shows the wrapped value. Back-to-back wraps give back-to-back pulses.
- Wrap tally:
  - BCD increments on the same edge wrap_pulse rises.
  - Ones digit 9 → 0 with carry into tens; 99 → 00 rollover.
  - clear_wraps loads 00 on the next edge and has priority over a simultaneous increment (that wrap is lost). wrap_pulse itself is unaffected.
- Display refresh:
  - Divider counts 0..REFRESH_DIV-1.
  - At terminal value the divider returns to 0 and the scan index advances 0→1→2→3→0.
- Digit content by scan index:
  - 0: ones of c1 (c1 ≥ 10 gives c1-10).
  - 1: tens of c1 (1 if c1 ≥ 10), blank when 0.
  - 2: wraps ones.
  - 3: wraps tens, never blanked.
- Segment decode, active-high form: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, blank=00.
- dp is lit only while index=0 and d1=1.
- seg, dp and an are registered, one cycle after the scan index/content they reflect.
- Exactly one an bit is active outside reset; the first active digit after reset release is an[0], asserted on the first edge.
- Polarity parameters invert seg/dp and an after decode.

Test Plan:
- Reset then release, count=0, N=10, dir=0 → after 1 edge an=4'b1110, seg=7'h40 (digit "0" active-low); after REFRESH_DIV edges an=4'b1101 with digit blank, seg=7'h7F.
- N=10, up, count walks 0..9,0 → one wrap_pulse 3 edges after count=0 is presented; wraps=8'h01.
- N=10, down, count 1,0,9 → one pulse; wraps increments. count 9,8,0 (non-wrap jump) → no pulse.
- Drive 100 consecutive up wraps (N=2, alternating 1,0) → wraps reaches 8'h99 then 8'h00; each pulse is one cycle wide.
- N=1, count held 0, both directions → no pulse. N=0, count 15→0 up → one pulse.
- clear_wraps asserted on the same edge as a pulse with wraps=8'h05 → wraps=8'h00, not 8'h06. Async reset mid-scan (index 2) → an inactive immediately, restart at an[0].
- count=13, dir=1, SEG_ACTIVE_LOW=0 → index 0 shows seg=7'h4F with dp=1; index 1 shows seg=7'h06.
